// File: rtl/tcm_mem_pkg.sv
//==============================================================================
// Module      : tcm_mem_pkg
// Description : Shared FSM state type and read-mode constants for the
//               dual-port TCM RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package tcm_mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } tcm_state_t;

    localparam int MODE_READ_FIRST  = 0;
    localparam int MODE_WRITE_FIRST = 1;

endpackage

`default_nettype wire

// File: rtl/tcm_mem_port_pipe.sv
//==============================================================================
// Module      : tcm_mem_port_pipe
// Description : Per-port read-data capture plus optional output register;
//               data holds between valid pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tcm_mem_port_pipe #(
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_v1;
    logic [DATA_W-1:0] r_d1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= valid_i;
            if (valid_i) begin
                r_d1 <= data_i;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_v2;
            logic [DATA_W-1:0] r_d2;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= r_d1;
                    end
                end
            end

            assign valid_o = r_v2;
            assign data_o  = r_d2;
        end else begin : g_no_out_reg
            assign valid_o = r_v1;
            assign data_o  = r_d1;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tcm_mem_ram_mp.sv
//==============================================================================
// Module      : tcm_mem_ram_mp
// Description : Two-port byte-writable TCM RAM with optional zero-fill after
//               reset, read-first/write-first mode and optional output reg.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tcm_mem_ram_mp
    import tcm_mem_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int WRITE_FIRST = 0,
    parameter int OUT_REG     = 0,
    parameter int INIT_ZERO   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_i,
    input  logic [ADDR_W-1:0]   addr0_i,
    input  logic [DATA_W-1:0]   data0_i,
    input  logic [DATA_W/8-1:0] wr0_i,
    output logic [DATA_W-1:0]   data0_o,
    output logic                valid0_o,
    input  logic                req1_i,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [DATA_W-1:0]   data1_i,
    input  logic [DATA_W/8-1:0] wr1_i,
    output logic [DATA_W-1:0]   data1_o,
    output logic                valid1_o,
    output logic                ready_o,
    output logic                collision_o
);

    localparam int         NB          = DATA_W / 8;
    localparam int         DEPTH       = 1 << ADDR_W;
    localparam tcm_state_t C_RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    tcm_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt, w_init_cnt_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_collision;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_acc0, w_acc1, w_same, w_collide;
    logic [DATA_W-1:0] w_rd0, w_rd1;

    assign w_acc0    = req0_i && r_ready;
    assign w_acc1    = req1_i && r_ready;
    assign w_same    = (addr0_i == addr1_i);
    assign w_collide = w_acc0 && w_acc1 && w_same && (|wr0_i) && (|wr1_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= C_RST_STATE;
            r_init_cnt  <= '0;
            r_ready     <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_cnt  <= w_init_cnt_nxt;
            r_ready     <= w_ready_nxt;
            r_collision <= w_collide;
        end
    end

    // Counter stops on all-ones so it never wraps back to word 0.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_ready_nxt    = r_ready;
        case (r_state)
            ST_INIT: begin
                if (&r_init_cnt) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + ADDR_W'(1);
                end
            end
            ST_RUN:  w_ready_nxt = 1'b1;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Port 0 owns every lane it enables when both ports hit the same word.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_INIT) begin
            if (rst_i) begin
                r_mem[r_init_cnt] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_acc0 && wr0_i[b]) begin
                    r_mem[addr0_i][b*8 +: 8] <= data0_i[b*8 +: 8];
                end
                if (w_acc1 && wr1_i[b] && !(w_same && w_acc0 && wr0_i[b])) begin
                    r_mem[addr1_i][b*8 +: 8] <= data1_i[b*8 +: 8];
                end
            end
        end
    end

    generate
        if (WRITE_FIRST == MODE_WRITE_FIRST) begin : g_write_first
            always_comb begin
                w_rd0 = r_mem[addr0_i];
                w_rd1 = r_mem[addr1_i];
                for (int b = 0; b < NB; b++) begin
                    if (w_acc1 && wr1_i[b] && w_same) w_rd0[b*8 +: 8] = data1_i[b*8 +: 8];
                    if (w_acc0 && wr0_i[b])           w_rd0[b*8 +: 8] = data0_i[b*8 +: 8];
                    if (w_acc1 && wr1_i[b])           w_rd1[b*8 +: 8] = data1_i[b*8 +: 8];
                    if (w_acc0 && wr0_i[b] && w_same) w_rd1[b*8 +: 8] = data0_i[b*8 +: 8];
                end
            end
        end else begin : g_read_first
            assign w_rd0 = r_mem[addr0_i];
            assign w_rd1 = r_mem[addr1_i];
        end
    endgenerate

    tcm_mem_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (w_acc0),
        .data_i  (w_rd0),
        .valid_o (valid0_o),
        .data_o  (data0_o)
    );

    tcm_mem_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_pipe1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (w_acc1),
        .data_i  (w_rd1),
        .valid_o (valid1_o),
        .data_o  (data1_o)
    );

    assign ready_o     = r_ready;
    assign collision_o = r_collision;

endmodule

`default_nettype wire

// File: tb/tb_tcm_mem_ram_mp.sv
//==============================================================================
// Module      : tb_tcm_mem_ram_mp
// Description : Scoreboard bench for tcm_mem_ram_mp; a read-first/L=1 and a
//               write-first/L=2 instance share one stimulus stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tcm_mem_ram_mp;
    import tcm_mem_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req0_i = 1'b0, req1_i = 1'b0;
    logic [AW-1:0] addr0_i = '0, addr1_i = '0;
    logic [DW-1:0] data0_i = '0, data1_i = '0;
    logic [NB-1:0] wr0_i = '0, wr1_i = '0;

    logic [DW-1:0] data_rf0, data_rf1, data_wf0, data_wf1;
    logic          valid_rf0, valid_rf1, valid_wf0, valid_wf1;
    logic          ready_rf, ready_wf, coll_rf, coll_wf;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] mdl [16];
    exp_t          q [4][$];
    int            coll_q [$];
    logic [DW-1:0] last_d [4];
    logic          exp_coll;
    int            n;

    tcm_mem_ram_mp #(
        .ADDR_W(AW), .DATA_W(DW), .WRITE_FIRST(MODE_READ_FIRST), .OUT_REG(0), .INIT_ZERO(1)
    ) u_dut_rf (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .addr0_i(addr0_i), .data0_i(data0_i), .wr0_i(wr0_i),
        .data0_o(data_rf0), .valid0_o(valid_rf0),
        .req1_i(req1_i), .addr1_i(addr1_i), .data1_i(data1_i), .wr1_i(wr1_i),
        .data1_o(data_rf1), .valid1_o(valid_rf1),
        .ready_o(ready_rf), .collision_o(coll_rf)
    );

    tcm_mem_ram_mp #(
        .ADDR_W(AW), .DATA_W(DW), .WRITE_FIRST(MODE_WRITE_FIRST), .OUT_REG(1), .INIT_ZERO(1)
    ) u_dut_wf (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_i(req0_i), .addr0_i(addr0_i), .data0_i(data0_i), .wr0_i(wr0_i),
        .data0_o(data_wf0), .valid0_o(valid_wf0),
        .req1_i(req1_i), .addr1_i(addr1_i), .data1_i(data1_i), .wr1_i(wr1_i),
        .data1_o(data_wf1), .valid1_o(valid_wf1),
        .ready_o(ready_wf), .collision_o(coll_wf)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic mon(input int idx, input logic v, input logic [DW-1:0] d);
        exp_t e;
        if (v) begin
            if (q[idx].size() == 0) begin
                chk($sformatf("spurious_valid%0d", idx), {31'd0, v}, '0);
            end else begin
                e = q[idx].pop_front();
                chk($sformatf("data%0d", idx), d, e.data);
                chk($sformatf("latency%0d", idx), cyc, e.cyc);
            end
            last_d[idx] = d;
        end else begin
            chk($sformatf("hold%0d", idx), d, last_d[idx]);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            mon(0, valid_rf0, data_rf0);
            mon(1, valid_rf1, data_rf1);
            mon(2, valid_wf0, data_wf0);
            mon(3, valid_wf1, data_wf1);
            exp_coll = (coll_q.size() > 0) && (coll_q[0] == cyc);
            if (coll_rf || coll_wf || exp_coll) begin
                chk("collision_rf", {31'd0, coll_rf}, {31'd0, exp_coll});
                chk("collision_wf", {31'd0, coll_wf}, {31'd0, exp_coll});
                if (exp_coll) void'(coll_q.pop_front());
            end
        end
    end

    task automatic flush();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            last_d[k] = '0;
        end
        coll_q.delete();
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset(input int c);
        rst_i  = 1'b0;
        req0_i = 1'b0;
        req1_i = 1'b0;
        flush();
        #1;
        chk("rst_ready", {31'd0, ready_rf}, '0);
        chk("rst_valid_rf0", {31'd0, valid_rf0}, '0);
        chk("rst_valid_wf1", {31'd0, valid_wf1}, '0);
        chk("rst_coll", {31'd0, coll_rf | coll_wf}, '0);
        chk("rst_data_rf0", data_rf0, '0);
        chk("rst_data_wf1", data_wf1, '0);
        repeat (c) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready_rf && cnt < 100) begin
            @(posedge clk_i);
            #1;
            cnt++;
        end
    endtask

    task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [NB-1:0] w0,
                         input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [NB-1:0] w1);
        logic [DW-1:0] old0, old1;
        req0_i = r0; addr0_i = a0; data0_i = d0; wr0_i = w0;
        req1_i = r1; addr1_i = a1; data1_i = d1; wr1_i = w1;
        if (ready_rf) begin
            old0 = mdl[a0];
            old1 = mdl[a1];
            for (int b = 0; b < NB; b++)
                if (r1 && w1[b]) mdl[a1][b*8 +: 8] = d1[b*8 +: 8];
            for (int b = 0; b < NB; b++)
                if (r0 && w0[b]) mdl[a0][b*8 +: 8] = d0[b*8 +: 8];
            if (r0) begin
                q[0].push_back('{old0, 32'(cyc + 1)});
                q[2].push_back('{mdl[a0], 32'(cyc + 2)});
            end
            if (r1) begin
                q[1].push_back('{old1, 32'(cyc + 1)});
                q[3].push_back('{mdl[a1], 32'(cyc + 2)});
            end
            if (r0 && r1 && (a0 == a1) && (|w0) && (|w1))
                coll_q.push_back(cyc + 1);
        end
        @(posedge clk_i);
        #1;
        req0_i = 1'b0;
        req1_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        do_reset(3);
        wait_ready(n);
        chk("init_cycles", n, 16);
        for (int i = 0; i < 16; i++) mdl[i] = '0;

        for (int i = 0; i < 16; i++)
            drive(1'b1, AW'(i), '0, '0, 1'b1, AW'(15 - i), '0, '0);

        drive(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, '0, '0, '0);
        drive(1'b1, 4'd3, 32'h0000AA00, 4'h2, 1'b0, '0, '0, '0);
        drive(1'b1, 4'd3, '0, '0, 1'b0, '0, '0, '0);
        idle(3);

        drive(1'b1, 4'd5, 32'h11111111, 4'h3, 1'b1, 4'd5, 32'h22222222, 4'hF);
        drive(1'b1, 4'd5, '0, '0, 1'b1, 4'd5, '0, '0);
        idle(3);

        drive(1'b1, 4'd7, 32'hA5A5A5A5, 4'hF, 1'b0, '0, '0, '0);
        drive(1'b1, 4'd7, 32'h5A5A5A5A, 4'hF, 1'b1, 4'd7, '0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd7, '0, '0);
        idle(3);

        for (int i = 0; i < 32; i++)
            drive(1'b1, AW'(i % 16), DW'($urandom), '0,
                  1'b1, AW'($urandom_range(0, 15)), DW'($urandom), '0);
        idle(3);

        for (int i = 0; i < 64; i++)
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), DW'($urandom),
                  ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0,
                  $urandom_range(0, 3) != 0, AW'($urandom_range(0, 3)), DW'($urandom),
                  ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0);
        idle(3);

        // Reads of a non-zero word still in flight when reset hits.
        drive(1'b1, 4'd7, '0, '0, 1'b1, 4'd7, '0, '0);
        do_reset(2);
        idle(8);
        chk("mid_init_ready", {31'd0, ready_rf}, '0);
        do_reset(1);
        req0_i  = 1'b1;
        addr0_i = 4'd9;
        wait_ready(n);
        req0_i  = 1'b0;
        chk("reinit_cycles", n, 16);
        for (int i = 0; i < 16; i++) mdl[i] = '0;

        for (int i = 0; i < 4; i++)
            drive(1'b1, AW'(i * 4 + 1), '0, '0, 1'b1, AW'(i * 4 + 3), '0, '0);
        idle(4);

        for (int k = 0; k < 4; k++)
            chk($sformatf("pending%0d", k), q[k].size(), 0);
        chk("pending_coll", coll_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tcm_mem_ram_mp.md
TCM_MEM_RAM_MP -- requirements
Module: tcm_mem_ram_mp

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, word width; a multiple of 8; NB = DATA_W/8 byte lanes.
REQ-003 SHALL have parameter WRITE_FIRST, default 0; 0 = read-first, 1 = write-first.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds one output register stage per port.
REQ-005 SHALL have parameter INIT_ZERO, default 1; 1 = zero-fill the array after reset.
REQ-006 SHALL have port clk_i, input, 1, single clock shared by both ports; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-008 SHALL have, for p in {0,1}, port req<p>_i, input, 1, access request.
REQ-009 SHALL have port addr<p>_i, input, ADDR_W, word address.
REQ-010 SHALL have port data<p>_i, input, DATA_W, write data.
REQ-011 SHALL have port wr<p>_i, input, NB, byte write enables; 0 = read.
REQ-012 SHALL have port data<p>_o, output, DATA_W, read data.
REQ-013 SHALL have port valid<p>_o, output, 1, data<p>_o is valid this cycle.
REQ-014 SHALL have port ready_o, output, 1, block accepting requests.
REQ-015 SHALL have port collision_o, output, 1, one-cycle pulse on a same-address write/write conflict.

Function
REQ-016 SHALL accept a request on port p when req<p>_i && ready_o; requests while ready_o=0 SHALL be ignored and produce no valid<p>_o.
REQ-017 Every accepted request, read or write, SHALL assert valid<p>_o for exactly one cycle, L = 1+OUT_REG cycles later; one request per port per cycle, fully pipelined.
REQ-018 Writes SHALL update only lanes with wr<p>_i[b]=1; other lanes SHALL keep their contents.
REQ-019 With WRITE_FIRST=0, data<p>_o SHALL return the word as it was before any same-cycle write, from either port.
REQ-020 With WRITE_FIRST=1, data<p>_o SHALL return the word after all same-cycle writes, from both ports, have been merged per lane.
REQ-021 If both ports write the same address in the same cycle, port 0 SHALL win every lane it enables; port 1 SHALL write only lanes port 0 does not enable.
REQ-022 That case SHALL pulse collision_o one cycle later, whether or not the lanes overlap.
REQ-023 data<p>_o SHALL hold its last value when valid<p>_o=0.
REQ-024 The FSM SHALL have states INIT and RUN; reset enters INIT if INIT_ZERO=1, else RUN.
REQ-025 In INIT, a counter SHALL write zero to word 0..2**ADDR_W-1, one word per cycle, with ready_o=0.
REQ-026 After the final address the FSM SHALL go to RUN, with ready_o=1 from the next cycle; RUN SHALL be terminal until reset.
REQ-027 The init counter SHALL be exactly ADDR_W bits; the exit condition SHALL be counter all-ones, with no wrap to 0.

Reset
REQ-028 Reset assertion SHALL immediately clear data<p>_o, valid<p>_o, collision_o, ready_o, the init counter and the pipeline valids.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 Reset mid-INIT SHALL restart INIT from address 0.
REQ-031 Reset with reads in flight SHALL discard them; no valid SHALL follow reset release.

Structure
REQ-032 Package tcm_mem_pkg SHALL hold the FSM state typedef and the mode constants MODE_READ_FIRST and MODE_WRITE_FIRST.
REQ-033 The per-port output stage (optional register plus valid pipe) SHALL be the sub-module tcm_mem_port_pipe, instantiated twice.
REQ-034 The array SHALL be a single reg array written by one always block implementing the REQ-021 priority.

Verification
REQ-035 ADDR_W=4, INIT_ZERO=1: release reset -> ready_o=0 for 16 cycles, then 1; a read of every address -> 0x00000000.
REQ-036 Write 0xDEADBEEF with wr0=0xF to address 3, then wr0=0x2 with data 0x0000AA00 -> a read of address 3 returns 0xDEADAAEF with L=1; with OUT_REG=1 it returns L=2.
REQ-037 Same cycle, port 0 writes address 5 = 0x11111111 with wr0=0x3 and port 1 writes address 5 = 0x22222222 with wr1=0xF -> address 5 = 0x22221111, and collision_o pulses once.
REQ-038 Address 7 = 0xA5A5A5A5; port 1 reads address 7 while port 0 writes 0x5A5A5A5A -> data1_o = 0xA5A5A5A5 with WRITE_FIRST=0, 0x5A5A5A5A with WRITE_FIRST=1.
REQ-039 Assert rst_i at INIT address 8 -> ready_o=0 and INIT restarts at 0, taking 16 more cycles; a req0_i during INIT gives no valid0_o.
REQ-040 Back-to-back reads on both ports every cycle for 32 cycles -> 32 valid pulses per port, data in order.
